logic_sweep_ctrl: RTL and testbench

Self-test sequencer for the two-input `LOGIC` gate unit.
- On a start request it drives the unit's `A`/`B` inputs through all four combinations, 00, 01, 10, 11.
- It holds each combination for a programmable dwell time and captures `Y0..Y3` at the end of each dwell.
- It compares the 16 captured bits against an expected truth table and reports pass/fail plus a per-vector error mask.
- It sits beside `LOGIC` at the top level. It replaces the hand-written stimulus sequence so the gate unit can be checked on the board.

---
 rtl/logic_sweep_pkg.sv | 18 +
 rtl/logic_sweep_timer.sv | 30 +++
 rtl/logic_sweep_ctrl.sv | 148 ++++++++++++++
 tb/tb_logic_sweep_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_sweep_pkg.sv
// Shared types and helpers for the LOGIC gate-unit self-test sequencer.
package logic_sweep_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_CHECK = 2'd2,
      ST_DONE  = 2'd3
   } sweep_state_t;

   // Y0=AND, Y1=OR, Y2=XOR, Y3=NAND packed as {Y3,Y2,Y1,Y0} per vector {A,B}
   localparam logic [15:0] LOGIC_SWEEP_EXP_DEFAULT = 16'h3EE8;

   function automatic logic [3:0] nib(input logic [15:0] word, input logic [1:0] i);
      return word[4*i +: 4];
   endfunction

endpackage

// File: rtl/logic_sweep_timer.sv
// Dwell counter: counts enabled cycles and pulses tc on the last cycle of each dwell.
module logic_sweep_timer #(
   parameter int unsigned DWELL = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic tc
);

   localparam int unsigned W = $clog2(DWELL + 1);
   localparam logic [W-1:0] LAST = W'(DWELL - 1);

   logic [W-1:0] cnt;

   assign tc = enable && (cnt == LAST);

   // Count while enabled, wrapping to zero at the terminal count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (enable) begin
         cnt <= tc ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/logic_sweep_ctrl.sv
// Self-test sequencer for the two-input LOGIC gate unit: sweeps {A,B} through
// 00..11, captures Y0..Y3 per vector and compares against EXP.
// Optional feature: define LOGIC_SWEEP_ERRCNT_EN to add the saturating ERR_CNT output.
module logic_sweep_ctrl
   import logic_sweep_pkg::*;
#(
   parameter int unsigned DWELL = 4,
   parameter logic [15:0] EXP   = LOGIC_SWEEP_EXP_DEFAULT
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        START,
   input  logic        ABORT,
   input  logic        Y0,
   input  logic        Y1,
   input  logic        Y2,
   input  logic        Y3,
   output logic        A,
   output logic        B,
   output logic        BUSY,
   output logic        DONE,
   output logic        PASS,
   output logic [3:0]  ERR_MASK,
   output logic [15:0] RESULT
`ifdef LOGIC_SWEEP_ERRCNT_EN
   ,
   output logic [7:0]  ERR_CNT
`endif
);

   sweep_state_t state, state_nxt;

   logic [1:0]  idx;
   logic [1:0]  ab;
   logic [15:0] result;
   logic [3:0]  err_mask;
   logic        pass;
   logic [3:0]  mismatch;
   logic        start_sweep;
   logic        capture;
   logic        check;
   logic        timer_en;
   logic        tc;

   assign timer_en = (state == ST_DRIVE) && !ABORT;

   logic_sweep_timer #(.DWELL(DWELL)) u_timer (
      .clk    (CLK),
      .rst_n  (RST_N),
      .clear  (start_sweep),
      .enable (timer_en),
      .tc     (tc)
   );

   // State register
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Next-state and per-cycle control strobes; ABORT overrides everything
   always_comb begin
      state_nxt   = state;
      start_sweep = 1'b0;
      capture     = 1'b0;
      check       = 1'b0;
      if (ABORT) begin
         state_nxt = ST_IDLE;
      end else begin
         unique case (state)
            ST_IDLE, ST_DONE: begin
               if (START) begin
                  state_nxt   = ST_DRIVE;
                  start_sweep = 1'b1;
               end
            end
            ST_DRIVE: begin
               if (tc) begin
                  capture = 1'b1;
                  if (idx == 2'd3) state_nxt = ST_CHECK;
               end
            end
            ST_CHECK: begin
               check     = 1'b1;
               state_nxt = ST_DONE;
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   // Per-vector nibble comparison against the expected word
   always_comb begin
      mismatch = '0;
      for (int unsigned k = 0; k < 4; k++) begin
         mismatch[k] = (nib(result, 2'(k)) != nib(EXP, 2'(k)));
      end
   end

   // Stimulus, capture and result registers
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         idx      <= '0;
         ab       <= '0;
         result   <= '0;
         err_mask <= '0;
         pass     <= 1'b0;
      end else if (ABORT) begin
         ab <= '0;
      end else if (start_sweep) begin
         idx      <= '0;
         ab       <= '0;
         result   <= '0;
         err_mask <= '0;
         pass     <= 1'b0;
      end else if (capture) begin
         result[4*idx +: 4] <= {Y3, Y2, Y1, Y0};
         if (idx != 2'd3) begin
            idx <= idx + 2'd1;
            ab  <= idx + 2'd1;
         end
      end else if (check) begin
         ab       <= '0;
         err_mask <= mismatch;
         pass     <= (result == EXP);
      end
   end

`ifdef LOGIC_SWEEP_ERRCNT_EN
   // Failed-sweep counter, saturating, cleared only by reset
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         ERR_CNT <= '0;
      end else if (check && (result != EXP) && (ERR_CNT != 8'hFF)) begin
         ERR_CNT <= ERR_CNT + 8'd1;
      end
   end
`endif

   assign A        = ab[1];
   assign B        = ab[0];
   assign BUSY     = (state == ST_DRIVE) || (state == ST_CHECK);
   assign DONE     = (state == ST_DONE);
   assign PASS     = pass;
   assign ERR_MASK = err_mask;
   assign RESULT   = result;

endmodule

// File: tb/tb_logic_sweep_ctrl.sv
// Bench for logic_sweep_ctrl: two instances (DWELL=4 and DWELL=1) share stimulus,
// each driven by its own behavioural LOGIC gate model with an optional Y2 stuck-at-0.
module tb_logic_sweep_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic start = 1'b0;
   logic abort = 1'b0;
   logic stuck = 1'b0;

   logic        a [2];
   logic        b [2];
   logic [3:0]  y [2];
   logic        busy [2];
   logic        done [2];
   logic        pass [2];
   logic [3:0]  em [2];
   logic [15:0] res [2];
   logic [7:0]  ecnt [2];

   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   // Behavioural LOGIC unit: {NAND, XOR, OR, AND}, XOR optionally stuck at 0
   function automatic logic [3:0] gate(input logic ga, input logic gb, input logic st);
      return {~(ga & gb), (ga ^ gb) & ~st, ga | gb, ga & gb};
   endfunction

   assign y[0] = gate(a[0], b[0], stuck);
   assign y[1] = gate(a[1], b[1], stuck);

   logic_sweep_ctrl #(.DWELL(4)) u4 (
      .CLK(clk), .RST_N(rst_n), .START(start), .ABORT(abort),
      .Y0(y[0][0]), .Y1(y[0][1]), .Y2(y[0][2]), .Y3(y[0][3]),
      .A(a[0]), .B(b[0]), .BUSY(busy[0]), .DONE(done[0]), .PASS(pass[0]),
      .ERR_MASK(em[0]), .RESULT(res[0])
`ifdef LOGIC_SWEEP_ERRCNT_EN
      , .ERR_CNT(ecnt[0])
`endif
   );

   logic_sweep_ctrl #(.DWELL(1)) u1 (
      .CLK(clk), .RST_N(rst_n), .START(start), .ABORT(abort),
      .Y0(y[1][0]), .Y1(y[1][1]), .Y2(y[1][2]), .Y3(y[1][3]),
      .A(a[1]), .B(b[1]), .BUSY(busy[1]), .DONE(done[1]), .PASS(pass[1]),
      .ERR_MASK(em[1]), .RESULT(res[1])
`ifdef LOGIC_SWEEP_ERRCNT_EN
      , .ERR_CNT(ecnt[1])
`endif
   );

`ifndef LOGIC_SWEEP_ERRCNT_EN
   assign ecnt[0] = '0;
   assign ecnt[1] = '0;
`endif

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // m_n counts edges since the edge that accepted START; everything else
   // follows from the sweep arithmetic (vector = n / DWELL, capture at multiples).
   localparam logic [15:0] EXP_WORD = 16'h3EE8;
   int          dw [2] = '{4, 1};
   logic        m_busy [2];
   logic        m_done [2];
   int          m_n [2];
   logic [15:0] m_res [2];
   logic        m_pass [2];
   logic [3:0]  m_em [2];
   int          m_ecnt [2];

   always @(negedge clk) begin
      for (int j = 0; j < 2; j++) begin
         if (!rst_n) begin
            m_busy[j] = 1'b0; m_done[j] = 1'b0; m_n[j] = 0;
            m_res[j] = '0; m_pass[j] = 1'b0; m_em[j] = '0; m_ecnt[j] = 0;
         end
         // compare
         chk($sformatf("u%0d busy", j), 32'(busy[j]), 32'(m_busy[j]));
         chk($sformatf("u%0d done", j), 32'(done[j]), 32'(m_done[j]));
         chk($sformatf("u%0d result", j), 32'(res[j]), 32'(m_res[j]));
         chk($sformatf("u%0d pass", j), 32'(pass[j]), 32'(m_pass[j]));
         chk($sformatf("u%0d err_mask", j), 32'(em[j]), 32'(m_em[j]));
`ifdef LOGIC_SWEEP_ERRCNT_EN
         chk($sformatf("u%0d err_cnt", j), 32'(ecnt[j]), 32'(m_ecnt[j]));
`endif
         if (!m_busy[j])
            chk($sformatf("u%0d ab idle", j), 32'({a[j], b[j]}), 32'd0);
         else if (m_n[j] < 4*dw[j])
            chk($sformatf("u%0d ab vec", j), 32'({a[j], b[j]}), 32'(m_n[j] / dw[j]));
         // advance to the state after the next rising edge
         if (rst_n) begin
            if (abort) begin
               m_busy[j] = 1'b0; m_done[j] = 1'b0;
            end else if (!m_busy[j]) begin
               if (start) begin
                  m_busy[j] = 1'b1; m_done[j] = 1'b0; m_n[j] = 0;
                  m_res[j] = '0; m_pass[j] = 1'b0; m_em[j] = '0;
               end
            end else begin
               m_n[j]++;
               if (m_n[j] % dw[j] == 0 && m_n[j] <= 4*dw[j]) begin
                  int k;
                  logic [1:0] kv;
                  k = m_n[j] / dw[j] - 1;
                  kv = 2'(k);
                  m_res[j][4*k +: 4] = gate(kv[1], kv[0], stuck);
               end
               if (m_n[j] == 4*dw[j] + 1) begin
                  m_busy[j] = 1'b0; m_done[j] = 1'b1;
                  m_pass[j] = (m_res[j] == EXP_WORD);
                  for (int k = 0; k < 4; k++)
                     m_em[j][k] = (m_res[j][4*k +: 4] != EXP_WORD[4*k +: 4]);
                  if (!m_pass[j] && m_ecnt[j] < 255) m_ecnt[j]++;
               end
            end
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // After the accepting edge: run until u4 reports DONE, recording when each DONE rose
   task automatic run_to_done(input int first_c, output int c4, output int c1);
      c4 = 0; c1 = 0;
      for (int c = first_c; c <= 60 && c4 == 0; c++) begin
         tick;
         if (done[1] && c1 == 0) c1 = c;
         if (done[0] && c4 == 0) c4 = c;
      end
   endtask

   initial begin
      int c4, c1;
      #1 rst_n = 1'b0;
      tick; tick;
      chk("reset busy", 32'(busy[0]), 32'd0);
      chk("reset result", 32'(res[0]), 32'd0);
      chk("reset ab", 32'({a[0], b[0]}), 32'd0);
      rst_n = 1'b1;
      tick;

      // 1. nominal
      start = 1'b1; tick; start = 1'b0;
      c4 = 0; c1 = 0;
      for (int c = 1; c <= 60 && c4 == 0; c++) begin
         tick;
         if (c == 4)  chk("nom ab vec1", 32'({a[0], b[0]}), 32'd1);
         if (c == 8)  chk("nom ab vec2", 32'({a[0], b[0]}), 32'd2);
         if (c == 12) chk("nom ab vec3", 32'({a[0], b[0]}), 32'd3);
         if (done[1] && c1 == 0) c1 = c;
         if (done[0] && c4 == 0) c4 = c;
      end
      chk("nom latency d4", 32'(c4), 32'd17);
      chk("nom latency d1", 32'(c1), 32'd5);
      chk("nom result", 32'(res[0]), 32'h3EE8);
      chk("nom pass", 32'(pass[0]), 32'd1);
      chk("nom err_mask", 32'(em[0]), 32'd0);
      tick;

      // 2. Y2 stuck at 0
      stuck = 1'b1;
      start = 1'b1; tick; start = 1'b0;
      run_to_done(1, c4, c1);
      chk("fault result", 32'(res[0]), 32'h3AA8);
      chk("fault result d1", 32'(res[1]), 32'h3AA8);
      chk("fault pass", 32'(pass[0]), 32'd0);
      chk("fault err_mask", 32'(em[0]), 32'b0110);
`ifdef LOGIC_SWEEP_ERRCNT_EN
      chk("fault err_cnt 1", 32'(ecnt[0]), 32'd1);
`endif
      start = 1'b1; tick; start = 1'b0;
      run_to_done(1, c4, c1);
`ifdef LOGIC_SWEEP_ERRCNT_EN
      chk("fault err_cnt 2", 32'(ecnt[0]), 32'd2);
`endif
      stuck = 1'b0;
      tick;

      // 3. abort during vector 2
      start = 1'b1; tick; start = 1'b0;
      repeat (9) tick;
      chk("abort pre ab", 32'({a[0], b[0]}), 32'd2);
      abort = 1'b1; tick; abort = 1'b0;
      chk("abort busy", 32'(busy[0]), 32'd0);
      chk("abort done", 32'(done[0]), 32'd0);
      chk("abort ab", 32'({a[0], b[0]}), 32'd0);
      chk("abort retained", 32'(res[0]), 32'h00E8);
      start = 1'b1; abort = 1'b1; tick; start = 1'b0; abort = 1'b0;
      chk("start+abort idle", 32'(busy[0]), 32'd0);
      tick;

      // 4. reset during vector 1
      start = 1'b1; tick; start = 1'b0;
      repeat (5) tick;
      #1 rst_n = 1'b0;
      #1;
      chk("async rst busy", 32'(busy[0]), 32'd0);
      chk("async rst ab", 32'({a[0], b[0]}), 32'd0);
      chk("async rst result", 32'(res[0]), 32'd0);
      tick;
      rst_n = 1'b1;
      tick;
      start = 1'b1; tick; start = 1'b0;
      run_to_done(1, c4, c1);
      chk("post rst latency", 32'(c4), 32'd17);
      chk("post rst result", 32'(res[0]), 32'h3EE8);
      tick;

      // 5. START pulses while busy are ignored
      start = 1'b1; tick; start = 1'b0;
      tick;
      start = 1'b1; tick; start = 1'b0;
      run_to_done(3, c4, c1);
      chk("min dwell latency", 32'(c1), 32'd5);
      chk("busy start d4 latency", 32'(c4), 32'd17);
      chk("min dwell result", 32'(res[1]), 32'h3EE8);
      tick;

      // 6. START held through DONE restarts
      start = 1'b1; tick;
      run_to_done(1, c4, c1);
      chk("hold latency", 32'(c4), 32'd17);
      tick;
      chk("restart busy", 32'(busy[0]), 32'd1);
      chk("restart result", 32'(res[0]), 32'd0);
      chk("restart pass", 32'(pass[0]), 32'd0);
      start = 1'b0;
      run_to_done(1, c4, c1);
      chk("restart complete", 32'(done[0]), 32'd1);
      tick; tick;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
